// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS receive path.
package dvs_ravens_pkg;

  localparam int unsigned CLK_PERIOD_NS  = 10;
  localparam int unsigned DVS_WIDTH_PXLS = 320;

  localparam int unsigned DVS_X_BITS     = 9;
  localparam int unsigned DVS_Y_BITS     = 9;
  localparam int unsigned DVS_TS_BITS    = 16;
  localparam int unsigned DVS_EVENT_BITS = 1 + DVS_X_BITS + DVS_Y_BITS + DVS_TS_BITS;

  typedef struct packed {
    logic                   pol;
    logic [DVS_Y_BITS-1:0]  y;
    logic [DVS_X_BITS-1:0]  x;
    logic [DVS_TS_BITS-1:0] ts;
  } dvs_ts_event_t;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCapture,
    StAckHi,
    StAckLo
  } rx_state_e;

  // Cycles covering the camera's 50 ns data-valid window after REQ.
  function automatic int unsigned settle_cycles(input int unsigned period_ns);
    return (50 + period_ns - 1) / period_ns;
  endfunction

endpackage

// File: rtl/dvs_aer_ts_event_receiver_fifo.sv
// Show-ahead synchronous event FIFO; pointers carry an extra wrap bit.
module dvs_event_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dvs_aer_ts_event_receiver.sv
// DVS AER receiver: 4-phase handshake, Y/X pairing, timestamping and event buffering.
module dvs_aer_ts_event_receiver
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned AER_W         = 10,
  parameter int unsigned X_BITS        = DVS_X_BITS,
  parameter int unsigned Y_BITS        = DVS_Y_BITS,
  parameter int unsigned TS_BITS       = DVS_TS_BITS,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned SETTLE_CYCLES = settle_cycles(CLK_PERIOD_NS),
  localparam int unsigned EVENT_BITS   = 1 + X_BITS + Y_BITS + TS_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AER_W-1:0]      aer,
  input  logic                  xsel,
  input  logic                  req,
  output logic                  ack,
  input  logic                  fifo_grant,
  output logic                  fifo_req,
  output logic [EVENT_BITS-1:0] fifo_bus_event,
  output logic [7:0]            orphan_cnt
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      settle_q, settle_d;
  logic                  req_meta_q, req_s_q;
  logic                  ack_q, ack_d;
  logic                  row_valid_q, row_valid_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  logic [7:0]            orphan_q, orphan_d;
  logic [TS_BITS-1:0]    ts_q;
  logic                  fifo_req_q, fifo_req_d;
  logic                  push, pop, full, empty;
  logic [EVENT_BITS-1:0] head, wdata;

  assign pop   = fifo_req_q && fifo_grant;
  assign wdata = {aer[0], y_q, aer[X_BITS:1], ts_q};

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    row_valid_d = row_valid_q;
    y_d         = y_q;
    orphan_d    = orphan_q;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The cycle that first sees req_s counts as the first settle cycle.
        if (req_s_q) begin
          settle_d = CNT_W'(1);
          state_d  = (SETTLE_CYCLES <= 1) ? StCapture : StSettle;
        end
      end
      StSettle: begin
        if (int'(settle_q) + 1 >= int'(SETTLE_CYCLES)) state_d = StCapture;
        else settle_d = settle_q + CNT_W'(1);
      end
      StCapture: begin
        if (!xsel) begin
          y_d         = aer[Y_BITS-1:0];
          row_valid_d = 1'b1;
          state_d     = StAckHi;
        end else if (!row_valid_q) begin
          if (orphan_q != 8'hff) orphan_d = orphan_q + 8'd1;
          state_d = StAckHi;
        end else if (!full || pop) begin
          push    = 1'b1;
          state_d = StAckHi;
        end
      end
      StAckHi: begin
        if (!req_s_q) state_d = StAckLo;
      end
      StAckLo: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ack_d      = (state_d == StAckHi);
    // Drop the request for one cycle after every pop so the arbiter releases grant.
    fifo_req_d = pop ? 1'b0 : !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      req_meta_q  <= 1'b0;
      req_s_q     <= 1'b0;
      ack_q       <= 1'b0;
      row_valid_q <= 1'b0;
      y_q         <= '0;
      orphan_q    <= '0;
      ts_q        <= '0;
      fifo_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      req_meta_q  <= req;
      req_s_q     <= req_meta_q;
      ack_q       <= ack_d;
      row_valid_q <= row_valid_d;
      y_q         <= y_d;
      orphan_q    <= orphan_d;
      ts_q        <= ts_q + TS_BITS'(1);
      fifo_req_q  <= fifo_req_d;
    end
  end

  dvs_event_fifo #(
    .WIDTH (EVENT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign ack            = ack_q;
  assign fifo_req       = fifo_req_q;
  assign fifo_bus_event = fifo_req_q ? head : '0;
  assign orphan_cnt     = orphan_q;

endmodule

// File: tb/tb_dvs_aer_ts_event_receiver.sv
// Directed bench for dvs_aer_ts_event_receiver with an event scoreboard.
module tb_dvs_aer_ts_event_receiver;

  localparam int SETTLE = 5;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  aer = '0;
  logic        xsel = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic        fifo_grant = 1'b1;
  logic        fifo_req;
  logic [34:0] fifo_bus_event;
  logic [7:0]  orphan_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [34:0] exp_q[$];
  logic [15:0] tb_ts;
  logic [8:0]  y_model = '0;
  bit          row_model = 1'b0;
  bit          prev_pop = 1'b0;

  always #5 clk = ~clk;

  dvs_aer_ts_event_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .aer            (aer),
    .xsel           (xsel),
    .req            (req),
    .ack            (ack),
    .fifo_grant     (fifo_grant),
    .fifo_req       (fifo_req),
    .fifo_bus_event (fifo_bus_event),
    .orphan_cnt     (orphan_cnt)
  );

  // Reference free-running timestamp.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops happen on the next rising edge; compare the head against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pop = 1'b0;
    end else begin
      if (prev_pop) check("req_gap_after_pop", fifo_req, 0);
      if (fifo_req && fifo_grant) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL extra_event: observed 0x%0h expected no event", fifo_bus_event);
        end
        if (exp_q.size() != 0) check("event", fifo_bus_event, exp_q.pop_front());
      end
      prev_pop = fifo_req && fifo_grant;
    end
  end

  task automatic wait_ack(input logic val, input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ack === val) seen = 1'b1;
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL %s: observed ack=%b expected %b within 40 cycles", tag, ack, val);
    end
  endtask

  task automatic send_word(input logic xs, input logic [9:0] data, output int rise,
                           output int fall);
    aer  = data;
    xsel = xs;
    req  = 1'b1;
    wait_ack(1'b1, "ack_rise", rise);
    if (!xs) begin
      y_model   = data[8:0];
      row_model = 1'b1;
    end else if (row_model) begin
      exp_q.push_back({data[0], y_model, data[9:1], tb_ts - 16'd1});
    end
    req = 1'b0;
    wait_ack(1'b0, "ack_fall", fall);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r, f;
    bit  ack_seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_fifo_req", fifo_req, 0);
    check("rst_bus_event", fifo_bus_event, 0);
    check("rst_orphan_cnt", orphan_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Orphan X words before any row.
    send_word(1'b1, 10'h027, r, f);
    check("orphan_one", orphan_cnt, 1);
    repeat (4) @(posedge clk);
    #1;
    check("orphan_no_req", fifo_req, 0);
    for (int i = 1; i < 300; i++) send_word(1'b1, 10'(i), r, f);
    check("orphan_saturate", orphan_cnt, 255);

    // Single Y/X pair with grant tied high.
    send_word(1'b0, 10'h05A, r, f);
    send_word(1'b1, {9'h013, 1'b1}, r, f);
    check("ack_rise_latency", r, SETTLE + 3);
    check("ack_fall_latency", f, 3);
    repeat (8) @(posedge clk);
    #1;
    check("single_drained", exp_q.size(), 0);

    // Row reuse over three X words.
    send_word(1'b0, 10'h010, r, f);
    send_word(1'b1, {9'h001, 1'b0}, r, f);
    send_word(1'b1, {9'h002, 1'b1}, r, f);
    send_word(1'b1, {9'h003, 1'b0}, r, f);
    repeat (8) @(posedge clk);
    #1;
    check("reuse_drained", exp_q.size(), 0);

    // Fill the FIFO with grant withheld, then stall one more X word.
    fifo_grant = 1'b0;
    send_word(1'b0, 10'h0AB, r, f);
    for (int i = 0; i < DEPTH; i++) send_word(1'b1, {9'(32 + i), 1'(i)}, r, f);
    check("full_fifo_req", fifo_req, 1);
    aer      = {9'h1FF, 1'b1};
    xsel     = 1'b1;
    req      = 1'b1;
    ack_seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ack) ack_seen = 1'b1;
    end
    check("ack_held_low_when_full", ack_seen, 0);
    fifo_grant = 1'b1;
    @(posedge clk);
    #1;
    fifo_grant = 1'b0;
    check("ack_after_single_pop", ack, 1);
    exp_q.push_back({1'b1, y_model, 9'h1FF, tb_ts - 16'd1});
    req = 1'b0;
    wait_ack(1'b0, "stall_ack_fall", f);
    check("pending_after_pop", exp_q.size(), DEPTH);
    fifo_grant = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("stall_drained", exp_q.size(), 0);
    check("stall_req_idle", fifo_req, 0);

    // Reset while ack is high, with req kept high across the reset.
    aer  = 10'h007;
    xsel = 1'b0;
    req  = 1'b1;
    wait_ack(1'b1, "pre_reset_ack", r);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_ack_async", ack, 0);
    check("reset_fifo_req", fifo_req, 0);
    check("reset_bus_event", fifo_bus_event, 0);
    row_model = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ack(1'b1, "rereq_ack_rise", r);
    check("rereq_latency", r, SETTLE + 3);
    y_model   = 9'h007;
    row_model = 1'b1;
    req       = 1'b0;
    wait_ack(1'b0, "rereq_ack_fall", f);
    check("reset_fifo_empty", fifo_req, 0);
    send_word(1'b1, {9'h0C5, 1'b1}, r, f);
    repeat (8) @(posedge clk);
    #1;
    check("reset_event_drained", exp_q.size(), 0);
    check("reset_orphan_cleared", orphan_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
